vga_timing_gen: RTL and testbench

- Raster timing stage directly upstream of the pong game engine.
- Generates the PIXEL_H/PIXEL_V scan coordinates that the engine consumes.
- Takes back the engine's registered 3-bit PIXEL colour and drives the DE0-Nano VGA pins.
- Delays sync and blanking internally so colour and sync leave the block cycle-aligned.
- Default timing: 800x600@72 Hz from a 50 MHz VGA_CLOCK.

---
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Raster timing generator for the pong engine. It produces the
//             horizontal/vertical scan coordinates the engine consumes and
//             takes back the engine's registered colour. Active and sync are
//             delayed so that colour and sync reach the DE0-Nano VGA pins on
//             the same edge. The default timing is 800x600@72 Hz from a
//             50 MHz pixel clock.
//
//  Ports    : VGA_CLOCK            in   pixel clock, rising edge
//             RESET_N              in   asynchronous active-low reset
//             PIXEL_H[10:0]        out  horizontal count 0..H_TOTAL-1
//             PIXEL_V[10:0]        out  vertical count 0..V_TOTAL-1
//             ACTIVE               out  undelayed visible-area decode
//             FRAME_START          out  one-clock pulse on wrap to (0,0)
//             PIXEL[2:0]           in   engine colour {R,G,B}, PIXEL_LATENCY
//                                       clocks behind its coordinate
//             VGA_R/VGA_G/VGA_B    out  colour pins
//             VGA_HSYNC/VGA_VSYNC  out  sync pins, asserted level SYNC_POL
//
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE     = 800,
    parameter int H_FRONT       = 56,
    parameter int H_SYNC        = 120,
    parameter int H_BACK        = 64,
    parameter int V_VISIBLE     = 600,
    parameter int V_FRONT       = 37,
    parameter int V_SYNC        = 6,
    parameter int V_BACK        = 23,
    parameter bit SYNC_POL      = 1'b1,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic        VGA_CLOCK,
    input  logic        RESET_N,
    output logic [10:0] PIXEL_H,
    output logic [10:0] PIXEL_V,
    output logic        ACTIVE,
    output logic        FRAME_START,
    input  logic [2:0]  PIXEL,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B,
    output logic        VGA_HSYNC,
    output logic        VGA_VSYNC
);

    localparam logic [10:0] c_H_TOTAL    = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [10:0] c_V_TOTAL    = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [10:0] c_H_LAST     = c_H_TOTAL - 11'd1;
    localparam logic [10:0] c_V_LAST     = c_V_TOTAL - 11'd1;
    localparam logic [10:0] c_H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] c_V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] c_HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0]              r_h;
    logic [10:0]              r_v;
    logic                     r_frame_start;
    logic                     w_active;
    logic                     w_hs_raw;
    logic                     w_vs_raw;
    logic [PIXEL_LATENCY-1:0] r_act_sr;
    logic [PIXEL_LATENCY-1:0] r_hs_sr;
    logic [PIXEL_LATENCY-1:0] r_vs_sr;
    logic [2:0]               r_rgb;
    logic                     r_hsync;
    logic                     r_vsync;

    // ------------------------------------------------------------------
    // Scan counters. FRAME_START is registered from the last position of
    // the frame, so it is high exactly while the counters sit at (0,0)
    // after a wrap and never during the first frame out of reset.
    // ------------------------------------------------------------------
    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_h           <= 11'd0;
            r_v           <= 11'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= (r_h == c_H_LAST) && (r_v == c_V_LAST);
            if (r_h == c_H_LAST) begin
                r_h <= 11'd0;
                r_v <= (r_v == c_V_LAST) ? 11'd0 : r_v + 11'd1;
            end else begin
                r_h <= r_h + 11'd1;
            end
        end
    end

    assign w_active = (r_h < c_H_VIS) && (r_v < c_V_VIS);
    assign w_hs_raw = (r_h >= c_HS_START) && (r_h < c_HS_END);
    assign w_vs_raw = (r_v >= c_VS_START) && (r_v < c_VS_END);

    // ------------------------------------------------------------------
    // Alignment pipeline. The decode is delayed by the engine's latency so
    // the delayed active lines up with the PIXEL that belongs to the same
    // coordinate; the output register then adds the final clock. Reset
    // clears every stage to blank with sync deasserted, so nothing stale
    // leaves the block after a mid-frame reset.
    // ------------------------------------------------------------------
    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_act_sr <= '0;
            r_hs_sr  <= '0;
            r_vs_sr  <= '0;
            r_rgb    <= 3'b000;
            r_hsync  <= ~SYNC_POL;
            r_vsync  <= ~SYNC_POL;
        end else begin
            r_act_sr[0] <= w_active;
            r_hs_sr[0]  <= w_hs_raw;
            r_vs_sr[0]  <= w_vs_raw;
            for (int i = 1; i < PIXEL_LATENCY; i++) begin
                r_act_sr[i] <= r_act_sr[i-1];
                r_hs_sr[i]  <= r_hs_sr[i-1];
                r_vs_sr[i]  <= r_vs_sr[i-1];
            end
            // Blanking forces black regardless of what the engine drives.
            r_rgb   <= r_act_sr[PIXEL_LATENCY-1] ? PIXEL : 3'b000;
            r_hsync <= r_hs_sr[PIXEL_LATENCY-1] ? SYNC_POL : ~SYNC_POL;
            r_vsync <= r_vs_sr[PIXEL_LATENCY-1] ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign PIXEL_H     = r_h;
    assign PIXEL_V     = r_v;
    assign ACTIVE      = w_active;
    assign FRAME_START = r_frame_start;
    assign VGA_R       = r_rgb[2];
    assign VGA_G       = r_rgb[1];
    assign VGA_B       = r_rgb[0];
    assign VGA_HSYNC   = r_hsync;
    assign VGA_VSYNC   = r_vsync;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Scoreboard bench for vga_timing_gen. Default horizontal timing,
//             shortened vertical timing (16 lines) so whole frames fit in a
//             short run. The main process plays the engine and pushes the
//             pin values each coordinate must produce; a monitor pops one
//             entry per clock and compares it with the pins.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int c_HT    = 1040;           // 800+56+120+64
    localparam int c_VT    = 16;             // 10+2+2+2
    localparam int c_FRAME = c_HT * c_VT;    // 16640 clocks

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } pins_t;

    logic        VGA_CLOCK = 1'b0;
    logic        RESET_N   = 1'b1;
    logic [2:0]  PIXEL     = 3'b111;
    logic [10:0] PIXEL_H;
    logic [10:0] PIXEL_V;
    logic        ACTIVE;
    logic        FRAME_START;
    logic        VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC;

    int    checks  = 0;
    int    errors  = 0;
    bit    running = 1'b0;
    pins_t exp_q[$];
    int    fs_count;

    vga_timing_gen #(
        .H_VISIBLE(800), .H_FRONT(56), .H_SYNC(120), .H_BACK(64),
        .V_VISIBLE(10),  .V_FRONT(2),  .V_SYNC(2),   .V_BACK(2),
        .SYNC_POL(1'b1), .PIXEL_LATENCY(1)
    ) dut (
        .VGA_CLOCK  (VGA_CLOCK),
        .RESET_N    (RESET_N),
        .PIXEL_H    (PIXEL_H),
        .PIXEL_V    (PIXEL_V),
        .ACTIVE     (ACTIVE),
        .FRAME_START(FRAME_START),
        .PIXEL      (PIXEL),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HSYNC  (VGA_HSYNC),
        .VGA_VSYNC  (VGA_VSYNC)
    );

    always #10 VGA_CLOCK = ~VGA_CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_active(input int h, input int v);
        return (h < 800) && (v < 10);
    endfunction

    // Engine colour: a pattern inside the visible area, white outside so
    // blanking has something to suppress.
    function automatic logic [2:0] color_of(input int h, input int v);
        if (is_active(h, v)) return 3'((h >> 1) ^ v);
        return 3'b111;
    endfunction

    function automatic pins_t expect_of(input int h, input int v);
        pins_t p;
        p.rgb = is_active(h, v) ? color_of(h, v) : 3'b000;
        p.hs  = (h >= 856) && (h < 976);
        p.vs  = (v >= 12) && (v < 14);
        return p;
    endfunction

    // Release mid-way through the high phase so cycle 0 is the next
    // negedge; the pins are blank for the first two output clocks.
    task automatic release_reset();
        @(posedge VGA_CLOCK);
        #5;
        exp_q.delete();
        exp_q.push_back(pins_t'(5'b0));
        exp_q.push_back(pins_t'(5'b0));
        RESET_N = 1'b1;
        running = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_h"},  32'(PIXEL_H), 0);
        check({tag, "_v"},  32'(PIXEL_V), 0);
        check({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 0);
        check({tag, "_hs"}, 32'(VGA_HSYNC), 0);
        check({tag, "_vs"}, 32'(VGA_VSYNC), 0);
        check({tag, "_fs"}, 32'(FRAME_START), 0);
    endtask

    task automatic run_cycles(input int n);
        int h, v, ph, pv;
        ph = 0; pv = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge VGA_CLOCK);
            h = k % c_HT;
            v = (k / c_HT) % c_VT;
            check("pixel_h", 32'(PIXEL_H), 32'(h));
            check("pixel_v", 32'(PIXEL_V), 32'(v));
            check("active", 32'(ACTIVE), 32'(is_active(h, v)));
            check("frame_start", 32'(FRAME_START), 32'((k > 0) && (k % c_FRAME == 0)));
            PIXEL = (k == 0) ? 3'b111 : color_of(ph, pv);
            exp_q.push_back(expect_of(h, v));
            ph = h; pv = v;
        end
    endtask

    // Monitor: one output sample per clock, plus hand-computed timing marks.
    int mk, hs_len, vs_len, last_fs;
    bit prev_hs, prev_vs, prev_fs, hs_done, vs_done;
    always @(negedge VGA_CLOCK) begin
        if (!running) begin
            mk = 0; hs_len = 0; vs_len = 0; last_fs = -1; fs_count = 0;
            prev_hs = 0; prev_vs = 0; prev_fs = 0; hs_done = 0; vs_done = 0;
        end else begin
            pins_t e;
            if (exp_q.size() == 0) begin
                check("queue_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e.rgb));
                check("hsync", 32'(VGA_HSYNC), 32'(e.hs));
                check("vsync", 32'(VGA_VSYNC), 32'(e.vs));
            end
            if (VGA_HSYNC && !prev_hs && !hs_done) check("hsync_rise", mk, 858);
            if (VGA_HSYNC) hs_len = prev_hs ? hs_len + 1 : 1;
            if (!VGA_HSYNC && prev_hs && !hs_done) begin
                check("hsync_width", hs_len, 120);
                hs_done = 1;
            end
            if (VGA_VSYNC && !prev_vs && !vs_done) check("vsync_rise", mk, 12 * c_HT + 2);
            if (VGA_VSYNC) vs_len = prev_vs ? vs_len + 1 : 1;
            if (!VGA_VSYNC && prev_vs && !vs_done) begin
                check("vsync_width", vs_len, 2 * c_HT);
                vs_done = 1;
            end
            if (FRAME_START) begin
                check("frame_start_width", 32'(prev_fs), 0);
                if (last_fs >= 0) check("frame_spacing", mk - last_fs, c_FRAME);
                last_fs = mk;
                fs_count++;
            end
            prev_hs = VGA_HSYNC; prev_vs = VGA_VSYNC; prev_fs = FRAME_START;
            mk++;
        end
    end

    initial begin
        #5 RESET_N = 1'b0;
        #1 check_reset_state("reset_async");
        repeat (3) @(posedge VGA_CLOCK);
        #1 check_reset_state("reset_held");
        release_reset();

        // Two whole frames, then stop at (500,5) of the third.
        run_cycles(2 * c_FRAME + 5 * c_HT + 500);
        @(negedge VGA_CLOCK);
        check("mid_h", 32'(PIXEL_H), 500);
        check("mid_v", 32'(PIXEL_V), 5);
        check("frame_pulses", fs_count, 2);
        check("mid_rgb_live", 32'({VGA_R, VGA_G, VGA_B}), 32'(color_of(498, 5)));

        // Mid-frame reset held for three clocks.
        #3;
        RESET_N = 1'b0;
        running = 1'b0;
        #1 check_reset_state("mid_reset_async");
        repeat (3) @(posedge VGA_CLOCK);
        #1 check_reset_state("mid_reset_held");
        release_reset();
        run_cycles(3000);

        @(negedge VGA_CLOCK);
        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
